csr_trap_ctrl: RTL and testbench



---
 rtl/csr_trap_ctrl.sv | 150 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
// Trap/return sequencer between WB, the CSR file and pre-IF: orders CSR commit strobes,
// runs the flush/redirect handshake after a trap or ertn, and injects pending interrupts once.
module csr_trap_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic        wb_ex_req,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_pc_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic        wb_ertn,
    input  logic        wb_csr_we,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_csr_wmask,
    input  logic [31:0] wb_csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era_in,
    input  logic        id_int_ack,
    input  logic        redirect_ready,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic [31:0] csr_vaddr,
    output logic        csr_ertn_flush,
    output logic        int_mark,
    output logic        pipe_flush,
    output logic        wb_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        target_q, target_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               int_inflight_q, int_inflight_d;

    logic               in_idle;
    logic               take_ex;
    logic               take_ertn;
    logic               take_csr;

    // Exception beats ertn beats CSR write; WB is only listened to in IDLE.
    assign in_idle   = (state_q == IDLE);
    assign take_ex   = in_idle && wb_valid && wb_ex_req;
    assign take_ertn = in_idle && wb_valid && !wb_ex_req && wb_ertn;
    assign take_csr  = in_idle && wb_valid && !wb_ex_req && !wb_ertn && wb_csr_we;

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        cnt_d          = cnt_q;
        int_inflight_d = int_inflight_q;

        csr_we         = take_csr;
        csr_num        = take_csr ? wb_csr_num : 14'd0;
        csr_wmask      = take_csr ? wb_csr_wmask : 32'd0;
        csr_wvalue     = take_csr ? wb_csr_wvalue : 32'd0;
        csr_wb_ex      = take_ex;
        csr_ecode      = take_ex ? wb_ecode_in : 6'd0;
        csr_esubcode   = take_ex ? wb_esubcode_in : 9'd0;
        csr_pc         = take_ex ? wb_pc_in : 32'd0;
        csr_vaddr      = take_ex ? wb_vaddr_in : 32'd0;
        csr_ertn_flush = take_ertn;

        int_mark       = has_int && in_idle && !int_inflight_q;
        pipe_flush     = 1'b0;
        wb_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (state_q)
            IDLE: begin
                if (take_ex) begin
                    target_d = ex_entry;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end else if (take_ertn) begin
                    target_d = era_in;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                pipe_flush = 1'b1;
                wb_stall   = 1'b1;
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REDIR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REDIR: begin
                pipe_flush     = 1'b1;
                wb_stall       = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trap/return commit or a withdrawn interrupt re-arms injection; clears win over a set.
        if (int_mark && id_int_ack) begin
            int_inflight_d = 1'b1;
        end
        if (take_ex || take_ertn || !has_int) begin
            int_inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            target_q       <= 32'd0;
            cnt_q          <= '0;
            int_inflight_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            cnt_q          <= cnt_d;
            int_inflight_q <= int_inflight_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: stimulus pushes expected commit/redirect events,
// a negedge monitor pops and compares them; cycle-level flush/stall/int checks run inline.
module tb_csr_trap_ctrl;

    localparam int FC = 3;
    localparam int EW = 99;

    localparam logic [2:0] K_CSR   = 3'd1;
    localparam logic [2:0] K_EXC   = 3'd2;
    localparam logic [2:0] K_ERTN  = 3'd3;
    localparam logic [2:0] K_REDIR = 3'd4;

    logic        clk;
    logic        resetn;
    logic        wb_valid;
    logic        wb_ex_req;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic [31:0] wb_pc_in;
    logic [31:0] wb_vaddr_in;
    logic        wb_ertn;
    logic        wb_csr_we;
    logic [13:0] wb_csr_num;
    logic [31:0] wb_csr_wmask;
    logic [31:0] wb_csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] era_in;
    logic        id_int_ack;
    logic        redirect_ready;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        csr_wb_ex;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_pc;
    logic [31:0] csr_vaddr;
    logic        csr_ertn_flush;
    logic        int_mark;
    logic        pipe_flush;
    logic        wb_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  dbg_state;

    logic [EW-1:0] exp_q[$];
    int errors;
    int checks;

    csr_trap_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_ex_req      (wb_ex_req),
        .wb_ecode_in    (wb_ecode_in),
        .wb_esubcode_in (wb_esubcode_in),
        .wb_pc_in       (wb_pc_in),
        .wb_vaddr_in    (wb_vaddr_in),
        .wb_ertn        (wb_ertn),
        .wb_csr_we      (wb_csr_we),
        .wb_csr_num     (wb_csr_num),
        .wb_csr_wmask   (wb_csr_wmask),
        .wb_csr_wvalue  (wb_csr_wvalue),
        .has_int        (has_int),
        .ex_entry       (ex_entry),
        .era_in         (era_in),
        .id_int_ack     (id_int_ack),
        .redirect_ready (redirect_ready),
        .csr_we         (csr_we),
        .csr_num        (csr_num),
        .csr_wmask      (csr_wmask),
        .csr_wvalue     (csr_wvalue),
        .csr_wb_ex      (csr_wb_ex),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_pc         (csr_pc),
        .csr_vaddr      (csr_vaddr),
        .csr_ertn_flush (csr_ertn_flush),
        .int_mark       (int_mark),
        .pipe_flush     (pipe_flush),
        .wb_stall       (wb_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dbg_state      (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic [2:0] k, input logic [31:0] x0,
                                         input logic [31:0] x1, input logic [31:0] x2);
        return {k, x0, x1, x2};
    endfunction

    function automatic logic [31:0] flags();
        return {25'd0, csr_we, csr_wb_ex, csr_ertn_flush, int_mark, pipe_flush, wb_stall, redirect_valid};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic clear_wb();
        wb_valid       = 1'b0;
        wb_ex_req      = 1'b0;
        wb_ecode_in    = 6'd0;
        wb_esubcode_in = 9'd0;
        wb_pc_in       = 32'd0;
        wb_vaddr_in    = 32'd0;
        wb_ertn        = 1'b0;
        wb_csr_we      = 1'b0;
        wb_csr_num     = 14'd0;
        wb_csr_wmask   = 32'd0;
        wb_csr_wvalue  = 32'd0;
    endtask

    task automatic drive_csr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        wb_valid      = 1'b1;
        wb_csr_we     = 1'b1;
        wb_csr_num    = num;
        wb_csr_wmask  = mask;
        wb_csr_wvalue = val;
    endtask

    task automatic drive_ex(input logic [5:0] ec, input logic [8:0] esub, input logic [31:0] pc,
                            input logic [31:0] va);
        wb_valid       = 1'b1;
        wb_ex_req      = 1'b1;
        wb_ecode_in    = ec;
        wb_esubcode_in = esub;
        wb_pc_in       = pc;
        wb_vaddr_in    = va;
    endtask

    // Scoreboard monitor
    task automatic compare_evt(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event %h, expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", name, act, e, $time);
            end
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            int n;
            n = int'(csr_we) + int'(csr_wb_ex) + int'(csr_ertn_flush);
            if (n != 0) begin
                checks++;
                if (n > 1) begin
                    errors++;
                    $display("FAIL one_strobe: got %0d strobes expected 1", n);
                end
            end
            if (csr_wb_ex)
                compare_evt("exc_commit", mk(K_EXC, {17'd0, csr_esubcode, csr_ecode}, csr_pc, csr_vaddr));
            else if (csr_ertn_flush)
                compare_evt("ertn_commit", mk(K_ERTN, 32'd0, 32'd0, 32'd0));
            else if (csr_we)
                compare_evt("csr_write", mk(K_CSR, {18'd0, csr_num}, csr_wmask, csr_wvalue));
            if (redirect_valid && redirect_ready)
                compare_evt("redirect", mk(K_REDIR, redirect_pc, 32'd0, 32'd0));
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        clear_wb();
        has_int = 1'b0;
        ex_entry = 32'd0;
        era_in = 32'd0;
        id_int_ack = 1'b0;
        redirect_ready = 1'b0;

        // Reset and release
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_reset_flags", flags(), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_reset_flags", flags(), 32'd0);
        chk("post_reset_state", {30'd0, dbg_state}, 32'd0);
        chk("post_reset_pc", redirect_pc, 32'd0);

        // Zero-latency CSR write
        cyc();
        drive_csr(14'h30, 32'hFFFF_FFFF, 32'h0000_1234);
        exp_q.push_back(mk(K_CSR, 32'h30, 32'hFFFF_FFFF, 32'h0000_1234));
        @(negedge clk);
        chk("csr_write_stall", {31'd0, wb_stall}, 32'd0);
        chk("csr_write_state", {30'd0, dbg_state}, 32'd0);

        // Exception with held-off redirect
        cyc();
        clear_wb();
        ex_entry = 32'h1C00_8000;
        drive_ex(6'h08, 9'h1A5, 32'h1C00_0040, 32'hDEAD_0000);
        exp_q.push_back(mk(K_EXC, {17'd0, 9'h1A5, 6'h08}, 32'h1C00_0040, 32'hDEAD_0000));
        @(negedge clk);
        chk("ex_t_flush", {31'd0, pipe_flush}, 32'd0);
        cyc();
        clear_wb();
        ex_entry = 32'hFFFF_0000;
        @(negedge clk);
        chk("ex_t1_flags", flags(), 32'b0000110);
        cyc();
        drive_csr(14'h5, 32'h1, 32'h1);
        @(negedge clk);
        chk("ex_t2_flags", flags(), 32'b0000110);
        cyc();
        clear_wb();
        @(negedge clk);
        chk("ex_t3_flags", flags(), 32'b0000110);
        for (int k = 0; k < 2; k++) begin
            cyc();
            @(negedge clk);
            chk("ex_redir_valid", {31'd0, redirect_valid}, 32'd1);
            chk("ex_redir_pc", redirect_pc, 32'h1C00_8000);
        end
        cyc();
        redirect_ready = 1'b1;
        exp_q.push_back(mk(K_REDIR, 32'h1C00_8000, 32'd0, 32'd0));
        @(negedge clk);
        chk("ex_t6_stall", {31'd0, wb_stall}, 32'd1);
        cyc();
        redirect_ready = 1'b0;
        @(negedge clk);
        chk("ex_t7_state", {30'd0, dbg_state}, 32'd0);
        chk("ex_t7_flags", flags(), 32'd0);

        // Exception, ertn and CSR write together: exception only
        cyc();
        ex_entry = 32'h1C00_A000;
        era_in = 32'h1C0F_0000;
        drive_ex(6'h0B, 9'h000, 32'h1C00_0080, 32'h0000_0010);
        wb_ertn = 1'b1;
        wb_csr_we = 1'b1;
        wb_csr_num = 14'h7;
        wb_csr_wmask = 32'hFFFF_FFFF;
        wb_csr_wvalue = 32'h5555_5555;
        exp_q.push_back(mk(K_EXC, {17'd0, 9'h000, 6'h0B}, 32'h1C00_0080, 32'h0000_0010));
        exp_q.push_back(mk(K_REDIR, 32'h1C00_A000, 32'd0, 32'd0));
        @(negedge clk);
        chk("prio_ertn", {31'd0, csr_ertn_flush}, 32'd0);
        chk("prio_csr_we", {31'd0, csr_we}, 32'd0);
        cyc();
        clear_wb();
        redirect_ready = 1'b1;
        repeat (2) cyc();
        cyc();
        @(negedge clk);
        chk("prio_t4_valid", {31'd0, redirect_valid}, 32'd1);
        cyc();
        drive_csr(14'h6, 32'h0000_FFFF, 32'hA5A5_5A5A);
        exp_q.push_back(mk(K_CSR, 32'h6, 32'h0000_FFFF, 32'hA5A5_5A5A));
        @(negedge clk);
        chk("prio_t5_state", {30'd0, dbg_state}, 32'd0);
        cyc();
        clear_wb();

        // Interrupt injection
        has_int = 1'b1;
        @(negedge clk);
        chk("int_mark_set", {31'd0, int_mark}, 32'd1);
        cyc();
        id_int_ack = 1'b1;
        @(negedge clk);
        chk("int_mark_ack_cycle", {31'd0, int_mark}, 32'd1);
        cyc();
        id_int_ack = 1'b0;
        @(negedge clk);
        chk("int_mark_inflight", {31'd0, int_mark}, 32'd0);
        cyc();
        ex_entry = 32'h1C00_C000;
        drive_ex(6'h00, 9'h000, 32'h1C00_0200, 32'h0);
        exp_q.push_back(mk(K_EXC, 32'd0, 32'h1C00_0200, 32'd0));
        exp_q.push_back(mk(K_REDIR, 32'h1C00_C000, 32'd0, 32'd0));
        @(negedge clk);
        chk("int_exc_mark", {31'd0, int_mark}, 32'd0);
        cyc();
        clear_wb();
        @(negedge clk);
        chk("int_flush_mark", {31'd0, int_mark}, 32'd0);
        repeat (3) cyc();
        cyc();
        @(negedge clk);
        chk("int_rearmed", {31'd0, int_mark}, 32'd1);
        cyc();
        id_int_ack = 1'b1;
        cyc();
        id_int_ack = 1'b0;
        @(negedge clk);
        chk("int_inflight_again", {31'd0, int_mark}, 32'd0);
        cyc();
        has_int = 1'b0;
        @(negedge clk);
        chk("int_no_pending", {31'd0, int_mark}, 32'd0);
        cyc();
        has_int = 1'b1;
        @(negedge clk);
        chk("int_rearm_by_drop", {31'd0, int_mark}, 32'd1);
        cyc();
        has_int = 1'b0;

        // Asynchronous reset in REDIR, then an ertn
        redirect_ready = 1'b0;
        cyc();
        ex_entry = 32'h1C00_E000;
        drive_ex(6'h01, 9'h000, 32'h1C00_0300, 32'h0);
        exp_q.push_back(mk(K_EXC, {17'd0, 9'h000, 6'h01}, 32'h1C00_0300, 32'd0));
        cyc();
        clear_wb();
        repeat (3) cyc();
        @(negedge clk);
        chk("arst_pre_valid", {31'd0, redirect_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_flags", flags(), 32'd0);
        chk("arst_pc", redirect_pc, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("arst_state", {30'd0, dbg_state}, 32'd0);
        cyc();
        era_in = 32'h1C00_0100;
        redirect_ready = 1'b1;
        wb_valid = 1'b1;
        wb_ertn = 1'b1;
        exp_q.push_back(mk(K_ERTN, 32'd0, 32'd0, 32'd0));
        exp_q.push_back(mk(K_REDIR, 32'h1C00_0100, 32'd0, 32'd0));
        cyc();
        clear_wb();
        era_in = 32'h0;
        repeat (2) cyc();
        cyc();
        @(negedge clk);
        chk("ertn_redir_pc", redirect_pc, 32'h1C00_0100);
        cyc();
        @(negedge clk);
        chk("ertn_back_idle", {30'd0, dbg_state}, 32'd0);

        // Final report
        repeat (2) cyc();
        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
